// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end.
//   state_t    : frame FSM states
//   OP_*       : RAM command opcodes carried in rx_data[9:8]
//   FRAME_BITS : MOSI bits per command frame after the select bit
package spi_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/spi_piso8.sv
// Load/shift-out register for the MISO path, MSB-first.
//   clk, rst : clock, synchronous active-high reset
//   clr      : drop any shift in progress, output returns to 0
//   load     : capture din; its MSB appears on sout the following cycle
//   din      : parallel byte to send
//   sout     : registered serial output, 0 when idle
//   busy     : a byte is being shifted out
//   last     : the current sout bit is the final one (ends on this edge)
module spi_piso8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         busy,
  output logic         last
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  sreg;
  logic [CW-1:0] left;   // bits still to present after the current one

  assign last = busy && (left == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg <= '0;
      left <= '0;
      busy <= 1'b0;
      sout <= 1'b0;
    end else if (load) begin
      sout <= din[W-1];
      sreg <= {din[W-2:0], 1'b0};
      left <= CW'(W-1);
      busy <= 1'b1;
    end else if (busy) begin
      if (last) begin
        sout <= 1'b0;
        busy <= 1'b0;
      end else begin
        sout <= sreg[W-1];
        sreg <= {sreg[W-2:0], 1'b0};
        left <= left - 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM. SCK is clk; MOSI/SS_n are
// sampled on the rising edge.
//   clk, rst  : clock / synchronous active-high reset
//   SS_n      : slave select, active-low; high aborts or ends a frame
//   MOSI      : serial in, MSB-first (select bit, then 10 command bits)
//   MISO      : serial out, MSB-first read byte, 0 otherwise
//   rx_data   : command word {opcode, addr/data}, held until next frame
//   rx_valid  : one-cycle strobe for rx_data
//   tx_data   : read byte from RAM
//   tx_valid  : one-cycle strobe for tx_data
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  state_t          state;
  logic [DATA_W:0] shift;
  logic [3:0]      cnt;
  logic            frame_done;   // all 10 bits taken; later MOSI bits ignored
  logic            tx_taken;     // read byte already accepted this frame
  logic            rd_addr_done;

  logic abort, load, piso_busy, piso_last;

  // SS_n high while a frame is open wins over everything, including bit 9.
  assign abort = (state != IDLE) && SS_n;
  // Only one read byte per READ_DATA frame, and only after rx_valid.
  assign load  = (state == READ_DATA) && frame_done && !tx_taken &&
                 tx_valid && !SS_n;

  spi_piso8 #(.W(DATA_W)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .load (load),
    .din  (tx_data),
    .sout (MISO),
    .busy (piso_busy),
    .last (piso_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift        <= '0;
      cnt          <= '0;
      frame_done   <= 1'b0;
      tx_taken     <= 1'b0;
      rd_addr_done <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        cnt        <= '0;
        frame_done <= 1'b0;
        tx_taken   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt        <= '0;
            frame_done <= 1'b0;
            tx_taken   <= 1'b0;
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          default: begin  // WRITE, READ_ADD, READ_DATA
            if (!frame_done) begin
              shift <= {shift[DATA_W-1:0], MOSI};
              cnt   <= cnt + 1'b1;
              if (cnt == 4'(FRAME_BITS-1)) begin
                rx_data    <= {shift, MOSI};
                rx_valid   <= 1'b1;
                frame_done <= 1'b1;
                if (state == READ_ADD) rd_addr_done <= 1'b1;
              end
            end
            if (load) tx_taken <= 1'b1;
            if (state == READ_DATA && piso_busy && piso_last)
              rd_addr_done <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_rx[$];

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rx_valid pops one expected command word.
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) begin
      vectors++;
      if (exp_rx.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: got rx_data=%h, nothing expected", rx_data);
      end else begin
        logic [9:0] e;
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          miscompares++;
          $display("FAIL rx_data: got %h, expected %h", rx_data, e);
        end
      end
    end
  end

  // Drive one frame from IDLE. abort_bit >= 0 raises SS_n together with that
  // data bit (0-based count of bits already sampled). noise pulses tx_valid
  // on every data bit; it must be ignored.
  task automatic send_frame(input logic sel, input logic [9:0] w,
                            input int abort_bit, input bit noise);
    logic exp_v;
    SS_n = 1'b0; MOSI = ~sel;
    tick;
    MOSI = sel;
    tick;
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i]; tx_valid = noise; tx_data = 8'hFF;
      if (9 - i == abort_bit) SS_n = 1'b1;
      exp_v = (i == 0) && (abort_bit < 0);
      if (exp_v) exp_rx.push_back(w);
      tick;
      vectors++;
      if (MISO !== 1'b0 || rx_valid !== exp_v) begin
        miscompares++;
        $display("FAIL frame_bit%0d: got miso=%b rx_valid=%b, expected miso=0 rx_valid=%b",
                 i, MISO, rx_valid, exp_v);
      end
      if (9 - i == abort_bit) break;
    end
    tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  task automatic end_frame;
    SS_n = 1'b1;
    tick;
    vectors++;
    if (MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL end_frame_miso: got %b, expected 0", MISO);
    end
  endtask

  // Called in the rx_valid cycle: return tx byte one cycle later.
  task automatic return_tx(input logic [7:0] b);
    tick;
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_valid_width: got %b, expected 0", rx_valid);
    end
    tx_valid = 1'b1; tx_data = b;
    tick;
    tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  task automatic expect_miso(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      vectors++;
      if (MISO !== b[i]) begin
        miscompares++;
        $display("FAIL miso_bit%0d: got %b, expected %b", i, MISO, b[i]);
      end
      tick;
    end
  endtask

  task automatic expect_miso_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (MISO !== 1'b0) begin
        miscompares++;
        $display("FAIL %s: cycle %0d got miso=%b, expected 0", tag, i, MISO);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; SS_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      MOSI = i[0];
      tick;
      vectors++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
        miscompares++;
        $display("FAIL reset: got miso=%b rx_valid=%b rx_data=%h, expected 0 0 000",
                 MISO, rx_valid, rx_data);
      end
    end
    SS_n = 1'b1; rst = 1'b0;
    tick;
    expect_miso_quiet(2, "post_reset_miso");
  endtask

  task automatic test_write;
    send_frame(1'b0, 10'h05A, -1, 1'b1);
    end_frame;
    send_frame(1'b0, 10'h1C3, -1, 1'b1);
    end_frame;
  endtask

  task automatic test_read_addr;
    send_frame(1'b1, 10'h25A, -1, 1'b0);
    end_frame;
  endtask

  task automatic test_read_data;
    send_frame(1'b1, 10'h300, -1, 1'b1);  // pre-rx_valid tx_valid ignored
    return_tx(8'hC3);
    expect_miso(8'hC3, 8);
    expect_miso_quiet(2, "miso_after_byte");
    end_frame;
    // rd_addr_done cleared: this frame is an address read, no MISO data
    send_frame(1'b1, 10'h2AA, -1, 1'b0);
    return_tx(8'h5A);
    expect_miso_quiet(9, "read_add_no_miso");
    end_frame;
  endtask

  task automatic test_abort;
    send_frame(1'b0, 10'h0F0, 5, 1'b0);
    tick;
    send_frame(1'b1, 10'h3A5, 9, 1'b0);
    expect_miso_quiet(2, "abort_idle_miso");
    // rd_addr_done survived the aborts: next read returns data
    send_frame(1'b1, 10'h3FF, -1, 1'b0);
    return_tx(8'hA5);
    expect_miso(8'hA5, 8);
    expect_miso_quiet(1, "miso_after_a5");
    end_frame;
  endtask

  task automatic test_mid_reset;
    send_frame(1'b1, 10'h211, -1, 1'b0);  // address read again
    end_frame;
    send_frame(1'b1, 10'h3C0, -1, 1'b0);
    return_tx(8'hC3);
    expect_miso(8'hC3, 3);
    rst = 1'b1; SS_n = 1'b1;
    tick;
    rst = 1'b0;
    expect_miso_quiet(8, "mid_reset_miso");
    // rd_addr_done was cleared by reset: next read is an address read
    send_frame(1'b1, 10'h2C3, -1, 1'b0);
    return_tx(8'hFF);
    expect_miso_quiet(9, "post_reset_read_add");
    end_frame;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_addr;
    test_read_data;
    test_abort;
    test_mid_reset;
    tick;
    vectors++;
    if (exp_rx.size() != 0) begin
      miscompares++;
      $display("FAIL rx_missing: %0d expected words never seen, expected 0", exp_rx.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
